// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit for the HI/LO path: WIDTH shift-add or
// restoring shift-subtract steps, then a sign-fix cycle, under a start/busy/done handshake.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero,
  output logic [1:0]       dbg_state
);

  // Handshake: start is sampled only in IDLE; busy is high from the accepting edge
  // through the FIX edge; done pulses one cycle with hi/lo/div_zero valid and busy low.
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh, div_trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot, rem;

  // A W-bit unsigned magnitude already holds |MIN| = 2^(W-1), so negating MIN is exact.
  assign sign_a = ~op[0] & a[WIDTH-1];
  assign sign_b = ~op[0] & b[WIDTH-1];
  assign a_mag  = sign_a ? (~a + WIDTH'(1)) : a;
  assign b_mag  = sign_b ? (~b + WIDTH'(1)) : b;

  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
  assign rem_sh    = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_trial = rem_sh - {1'b0, opnd_q};
  assign prod_fix  = neg_lo_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
  assign quot      = neg_lo_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
  assign rem       = neg_hi_q ? (~acc_q[2*WIDTH-1:WIDTH] + WIDTH'(1)) : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    done_d   = 1'b0;
    dz_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (op[1] && (b == '0)) begin
            done_d = 1'b1;
            dz_d   = 1'b1;
          end else begin
            is_div_d = op[1];
            neg_lo_d = sign_a ^ sign_b;
            neg_hi_d = op[1] & sign_a;
            acc_d    = op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
            opnd_d   = op[1] ? b_mag : a_mag;
            cnt_d    = '0;
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        if (is_div_q) begin
          // Restoring step: remainder in the upper half, quotient bits shift into the lower.
          if (!div_trial[WIDTH]) acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else                   acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) state_d = FIX;
      end
      FIX: begin
        if (is_div_q) begin
          hi_d = rem;
          lo_d = quot;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign div_zero  = dz_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, randomized ops against an
// arithmetic reference model, and hand-written handshake/reset sequences.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] a_i = '0, b_i = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;
  logic [1:0]  dbg_state;

  logic        start8 = 1'b0;
  logic [1:0]  op8 = 2'b00;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;
  logic [1:0]  dbg8;

  int n_tests = 0;
  int n_fail  = 0;

  logic [64:0] exp_q[$];

  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op_i), .a(a_i), .b(b_i),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero), .dbg_state(dbg_state)
  );

  muldiv_unit #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_zero(dz8), .dbg_state(dbg8)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; returns {hi, lo}. Caller handles b == 0.
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, sq, sr;
    logic [63:0] ua, ub, res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      2'b00:   res = 64'(sa * sb);
      2'b01:   res = ua * ub;
      2'b10:   begin sq = sa / sb; sr = sa % sb; res = {sr[31:0], sq[31:0]}; end
      default: begin res = {32'(ua % ub), 32'(ua / ub)}; end
    endcase
    return res;
  endfunction

  // ---------------- driver ----------------
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r_hi, output logic [31:0] r_lo,
                        output logic r_dz, output logic r_busy, output int edges,
                        output int busy_cyc);
    @(negedge clk);
    start = 1'b1; op_i = op; a_i = a; b_i = b;
    @(posedge clk); #1;
    start = 1'b0;
    op_i = 2'($urandom); a_i = $urandom; b_i = $urandom;
    edges = 1;
    busy_cyc = 0;
    while (!done && edges < 100) begin
      if (busy) busy_cyc++;
      @(posedge clk); #1;
      edges++;
    end
    r_hi = hi; r_lo = lo; r_dz = div_zero; r_busy = busy;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, exp_hi, exp_lo;
    logic        exp_dz;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] r_hi, r_lo, m_hi, m_lo;
    logic        r_dz, r_busy;
    int          edges, busy_cyc, pulses;
    logic [64:0] e;

    vecs[0] = '{2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[2] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vecs[3] = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[4] = '{2'b11, 32'd7,        32'd2,        32'd1,        32'd3,        1'b0};
    vecs[5] = '{2'b10, 32'd5,        32'd0,        32'd1,        32'd3,        1'b1};
    vecs[6] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[7] = '{2'b11, 32'd100,      32'd0,        32'h00000000, 32'h80000000, 1'b1};
    vecs[8] = '{2'b01, 32'd0,        32'h12345678, 32'd0,        32'd0,        1'b0};
    vecs[9] = '{2'b11, 32'd5,        32'd7,        32'd5,        32'd0,        1'b0};

    // ---------------- reset ----------------
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(div_zero), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // ---------------- directed table ----------------
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r_hi, r_lo, r_dz, r_busy, edges, busy_cyc);
      check($sformatf("vec%0d_hi", i), 64'(r_hi), 64'(vecs[i].exp_hi));
      check($sformatf("vec%0d_lo", i), 64'(r_lo), 64'(vecs[i].exp_lo));
      check($sformatf("vec%0d_dz", i), 64'(r_dz), 64'(vecs[i].exp_dz));
      check($sformatf("vec%0d_busy_at_done", i), 64'(r_busy), 64'd0);
      check($sformatf("vec%0d_latency", i), 64'(edges), vecs[i].exp_dz ? 64'd1 : 64'd34);
      check($sformatf("vec%0d_busy_cycles", i), 64'(busy_cyc), vecs[i].exp_dz ? 64'd0 : 64'd33);
    end

    // done and div_zero drop after their single cycle
    @(posedge clk); #1;
    check("pulse_done_drop", 64'(done), 64'd0);
    check("pulse_dz_drop", 64'(div_zero), 64'd0);

    // ---------------- randomized vs reference ----------------
    m_hi = hi;
    m_lo = lo;
    for (int i = 0; i < 150; i++) begin
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      logic [63:0] res;
      rop = 2'($urandom_range(3, 0));
      ra  = ($urandom_range(7, 0) == 0) ? 32'h80000000 : $urandom;
      rb  = $urandom;
      case ($urandom_range(9, 0))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFFFFFF;
        2:       rb = 32'($urandom_range(15, 1));
        default: ;
      endcase
      if (rop[1] && rb == 32'd0) begin
        exp_q.push_back({1'b1, m_hi, m_lo});
      end else begin
        res = ref_model(rop, ra, rb);
        m_hi = res[63:32];
        m_lo = res[31:0];
        exp_q.push_back({1'b0, m_hi, m_lo});
      end
      run_op(rop, ra, rb, r_hi, r_lo, r_dz, r_busy, edges, busy_cyc);
      e = exp_q.pop_front();
      check($sformatf("rnd%0d_op%0d_a%0h_b%0h", i, rop, ra, rb),
            {r_hi, r_lo}, e[63:0]);
      check($sformatf("rnd%0d_dz", i), 64'(r_dz), 64'(e[64]));
      check($sformatf("rnd%0d_latency", i), 64'(edges), e[64] ? 64'd1 : 64'd34);
    end

    // ---------------- start while busy is ignored ----------------
    @(negedge clk);
    start = 1'b1; op_i = 2'b01; a_i = 32'd3; b_i = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0;
    r_hi = '1; r_lo = '1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      start = (c == 3);
      if (c == 3) begin op_i = 2'b01; a_i = 32'd100; b_i = 32'd100; end
      @(posedge clk); #1;
      if (done) begin pulses++; r_hi = hi; r_lo = lo; end
    end
    start = 1'b0;
    check("busy_start_pulses", 64'(pulses), 64'd1);
    check("busy_start_hi", 64'(r_hi), 64'd0);
    check("busy_start_lo", 64'(r_lo), 64'd15);

    // ---------------- reset mid-operation ----------------
    @(negedge clk);
    start = 1'b1; op_i = 2'b00; a_i = 32'd9; b_i = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    check("midrst_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    check("midrst_no_done", 64'(pulses), 64'd0);

    // ---------------- WIDTH = 8 instance ----------------
    @(negedge clk);
    start8 = 1'b1; op8 = 2'b00; a8 = 8'h80; b8 = 8'h80;
    @(posedge clk); #1;
    start8 = 1'b0;
    edges = 1;
    while (!done8 && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    check("w8_latency", 64'(edges), 64'd10);
    check("w8_hi", 64'(hi8), 64'h40);
    check("w8_lo", 64'(lo8), 64'h00);
    check("w8_busy_at_done", 64'(busy8), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
